// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider_pkg
//  Purpose  : Shared FSM encoding and default width for the restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_restoring_divider_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider_if
//  Purpose  : Start/operand request and result bundle for the divider.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : seq_restoring_divider_if
`default_nettype wire

// File: rtl/seq_restoring_divider_ripple_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : ripple_subtractor
//  Purpose  : a - b as a ripple of full-adder cells on a and ~b, carry-in 1.
//  Revision : 1.0 - initial release
// ============================================================================
module ripple_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_b_n;

    assign w_carry[0] = 1'b1;
    assign w_b_n      = ~b;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign diff[i]      = a[i] ^ w_b_n[i] ^ w_carry[i];
            assign w_carry[i+1] = (a[i] & w_b_n[i]) | (w_carry[i] & (a[i] ^ w_b_n[i]));
        end
    endgenerate

    // Two's-complement subtraction: no carry out means a < b.
    assign borrow = ~w_carry[WIDTH];

endmodule : ripple_subtractor
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider
//  Purpose  : Multi-cycle unsigned restoring divider, one quotient bit/clock.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_restoring_divider_if.slave  bus
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]     w_s;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;

    // Shift the next dividend bit into the partial remainder before trial.
    assign w_s = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

    ripple_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a      (w_s),
        .b      (m_q),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        q_d           = q_q;
        m_d           = m_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_d       = RUN;
                        a_d           = '0;
                        q_d           = bus.dividend;
                        m_d           = {1'b0, bus.divisor};
                        count_d       = c_cnt_w'(WIDTH - 1);
                        div_by_zero_d = 1'b0;
                    end else begin
                        state_d       = DONE;
                        quotient_d    = '1;
                        remainder_d   = bus.dividend;
                        div_by_zero_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!w_borrow) begin
                    a_d = w_diff;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = w_s;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = q_d;
                    remainder_d = a_d[WIDTH-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            q_q           <= '0;
            m_q           <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            q_q           <= q_d;
            m_q           <= m_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_restoring_divider
//  Purpose  : Directed vectors, reset abort and full operand sweep (WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         noise;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one division and check result, latency, busy length and pulse width.
    // With noise set, start stays high with other operands through RUN and DONE.
    task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input logic noise, input string tag);
        int edges;
        int busy_cnt;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = noise;
        if (noise) begin
            bus.dividend = ~dvd;
            bus.divisor  = dvs ^ 4'h5;
        end
        edges    = 0;
        busy_cnt = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, " done_seen"}, int'(bus.done), 1);
        chk({tag, " latency_edges"}, edges, edz ? 0 : W);
        chk({tag, " busy_cycles"}, busy_cnt, edz ? 0 : W);
        chk({tag, " quotient"}, int'(bus.quotient), int'(eq));
        chk({tag, " remainder"}, int'(bus.remainder), int'(er));
        chk({tag, " div_by_zero"}, int'(bus.div_by_zero), int'(edz));
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, " done_one_cycle"}, int'(bus.done), 0);
        chk({tag, " quotient_hold"}, int'(bus.quotient), int'(eq));
    endtask

    initial begin
        int done_hits;

        vecs[0] = '{dvd: 4'd13, dvs: 4'd3, q: 4'd4,  r: 4'd1, dz: 1'b0, noise: 1'b0};
        vecs[1] = '{dvd: 4'd15, dvs: 4'd1, q: 4'd15, r: 4'd0, dz: 1'b0, noise: 1'b0};
        vecs[2] = '{dvd: 4'd2,  dvs: 4'd7, q: 4'd0,  r: 4'd2, dz: 1'b0, noise: 1'b0};
        vecs[3] = '{dvd: 4'd9,  dvs: 4'd0, q: 4'd15, r: 4'd9, dz: 1'b1, noise: 1'b0};
        vecs[4] = '{dvd: 4'd8,  dvs: 4'd2, q: 4'd4,  r: 4'd0, dz: 1'b0, noise: 1'b0};
        vecs[5] = '{dvd: 4'd11, dvs: 4'd2, q: 4'd5,  r: 4'd1, dz: 1'b0, noise: 1'b1};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset quotient", int'(bus.quotient), 0);
        chk("reset remainder", int'(bus.remainder), 0);
        chk("reset div_by_zero", int'(bus.div_by_zero), 0);
        @(posedge clk); #1;

        // Back-to-back: each issue lands on the first IDLE cycle after DONE.
        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
                    vecs[i].dz, vecs[i].noise, $sformatf("vec%0d", i));
        end

        // Reset during the second RUN cycle of 14/3.
        bus.dividend = 4'd14;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("abort busy_before", int'(bus.busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort done", int'(bus.done), 0);
        chk("abort quotient", int'(bus.quotient), 0);
        chk("abort remainder", int'(bus.remainder), 0);
        chk("abort div_by_zero", int'(bus.div_by_zero), 0);
        done_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_hits++;
        end
        chk("abort no_activity", done_hits, 0);
        run_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b0, "after_abort");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [W-1:0] eq;
                logic [W-1:0] er;
                eq = (b == 0) ? 4'hF : W'(a / b);
                er = (b == 0) ? W'(a) : W'(a % b);
                run_div(W'(a), W'(b), eq, er, (b == 0), 1'b0,
                        $sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_restoring_divider
`default_nettype wire
